// File: rtl/imem_loader.sv
// Instruction-memory writer: parses A5/count/data/checksum frames from a byte
// stream, issues one-cycle word writes and holds the core in reset while loading.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS    = 32,
   parameter int unsigned ADDR_W         = 5,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  HDR   = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_WRITE,
      S_CHECK
   } state_t;

   state_t              r_state;
   logic                r_in_ready;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [31:0]         r_wdata;
   logic                r_hold;
   logic                r_done;
   logic                r_err;
   logic [CNT_W-1:0]    r_words;
   logic [CNT_W-1:0]    r_total;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_idx;
   logic [23:0]         r_word;
   logic [7:0]          r_csum;
   logic [TMO_W-1:0]    r_tmo;

   state_t              w_next;
   logic                w_accept;
   logic                w_timeout;
   logic                w_oversize;
   logic                w_last_word;
   logic                w_clear;
   logic                w_set_err;
   logic                w_set_done;
   logic                w_next_err;

   assign w_accept    = in_valid & r_in_ready;
   assign w_timeout   = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_oversize  = (32'(in_data) > 32'(DEPTH_WORDS));
   assign w_last_word = ((r_words + CNT_W'(1)) == r_total);

   // Next-state and status-update decode
   always_comb begin
      w_next     = r_state;
      w_clear    = 1'b0;
      w_set_err  = 1'b0;
      w_set_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && (in_data == HDR)) begin
               w_next  = S_COUNT;
               w_clear = 1'b1;
            end
         end
         S_COUNT: begin
            if (w_accept) begin
               if (w_oversize) begin
                  w_next    = S_IDLE;
                  w_set_err = 1'b1;
               end else begin
                  w_next = S_DATA;
               end
            end else if (w_timeout) begin
               w_next    = S_IDLE;
               w_set_err = 1'b1;
            end
         end
         S_DATA: begin
            if (w_accept) begin
               if (r_idx == 2'd3) w_next = S_WRITE;
            end else if (w_timeout) begin
               w_next    = S_IDLE;
               w_set_err = 1'b1;
            end
         end
         S_WRITE: begin
            w_next = w_last_word ? S_CHECK : S_DATA;
         end
         S_CHECK: begin
            if (w_accept) begin
               w_next = S_IDLE;
               if (in_data == r_csum) w_set_done = 1'b1;
               else                   w_set_err  = 1'b1;
            end else if (w_timeout) begin
               w_next    = S_IDLE;
               w_set_err = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      w_next_err = w_clear ? 1'b0 : (w_set_err | r_err);
   end

   // State, registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b1;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_hold     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_words    <= '0;
         r_total    <= '0;
         r_addr     <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_csum     <= '0;
         r_tmo      <= '0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != S_WRITE);
         r_we       <= (w_next == S_WRITE);
         // A failed frame keeps the core held until a good frame lands
         r_hold     <= (w_next != S_IDLE) | w_next_err;

         if (w_clear) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= '0;
            r_csum  <= '0;
         end
         if (w_set_err)  r_err  <= 1'b1;
         if (w_set_done) r_done <= 1'b1;

         if (w_accept || (r_state == S_IDLE) || (r_state == S_WRITE)) r_tmo <= '0;
         else                                                          r_tmo <= r_tmo + TMO_W'(1);

         case (r_state)
            S_COUNT: begin
               if (w_accept && !w_oversize) begin
                  r_total <= (in_data == 8'd0) ? CNT_W'(DEPTH_WORDS) : CNT_W'(in_data);
                  r_addr  <= '0;
                  r_idx   <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  // Low byte arrives first; shifting right lands each byte in its lane
                  r_word <= {in_data, r_word[23:8]};
                  r_csum <= r_csum ^ in_data;
                  r_idx  <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_wdata <= {in_data, r_word};
                     r_waddr <= r_addr;
                  end
               end
            end
            S_WRITE: begin
               r_addr  <= r_addr + ADDR_W'(1);
               r_words <= r_words + CNT_W'(1);
               r_idx   <= '0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign imem_we      = r_we;
   assign imem_waddr   = r_waddr;
   assign imem_wdata   = r_wdata;
   assign core_hold    = r_hold;
   assign load_done    = r_done;
   assign load_error   = r_err;
   assign words_loaded = r_words;

endmodule
